// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard controller:
// forwarding selects, wait-FSM states, register-zero helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN,
      WAIT,
      ERR
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // x0 is hardwired, so it never produces or matches a hazard.
   function automatic logic reg_hit(
      input logic       we,
      input logic [4:0] rd,
      input logic [4:0] rs
   );
      return we && (rd != REG_ZERO) && (rd == rs);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller:
// register ids, stage flags, dmem handshake and control outputs.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   import hazard_pkg::*;

   logic [4:0]       Rs1D, Rs2D;
   logic [4:0]       Rs1E, Rs2E;
   logic [4:0]       RdE, RdM, RdW;
   logic             RegWriteM, RegWriteW;
   logic             LoadE, PCSrcE;
   logic             dmem_req, dmem_ack;
   logic             EnF, EnD, EnE, EnM, EnW;
   logic             FlushD, FlushE;
   fwd_sel_t         ForwardAE, ForwardBE;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E,
      output RdE, RdM, RdW,
      output RegWriteM, RegWriteW,
      output LoadE, PCSrcE,
      output dmem_req, dmem_ack,
      input  EnF, EnD, EnE, EnM, EnW,
      input  FlushD, FlushE,
      input  ForwardAE, ForwardBE,
      input  mem_err, stall_cycles
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E,
      input  RdE, RdM, RdW,
      input  RegWriteM, RegWriteW,
      input  LoadE, PCSrcE,
      input  dmem_req, dmem_ack,
      output EnF, EnD, EnE, EnM, EnW,
      output FlushD, FlushE,
      output ForwardAE, ForwardBE,
      output mem_err, stall_cycles
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Forwarding select for one EX operand;
// the MEM-stage result is younger, so it wins over WB.
module fwd_sel_unit
   import hazard_pkg::*;
(
   input  logic [4:0] RsE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   output fwd_sel_t   fwd
);

   always_comb begin
      fwd = FWD_NONE;
      if (reg_hit(RegWriteM, RdM, RsE))
         fwd = FWD_MEM;
      else if (reg_hit(RegWriteW, RdW, RsE))
         fwd = FWD_WB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage core,
// including the data-memory wait FSM with timeout.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int WC_W = $clog2(WAIT_MAX + 1);

   state_t           state, state_n;
   logic [WC_W-1:0]  wait_cnt, wait_cnt_n;
   logic             mem_err, mem_err_n;
   logic [CNT_W-1:0] stall_q;
   logic             freeze, lwstall, run;
   logic             en_f;
   fwd_sel_t         fwd_a, fwd_b;

   fwd_sel_unit u_fwd_a (
      .RsE       (hz.Rs1E),
      .RdM       (hz.RdM),
      .RdW       (hz.RdW),
      .RegWriteM (hz.RegWriteM),
      .RegWriteW (hz.RegWriteW),
      .fwd       (fwd_a)
   );

   fwd_sel_unit u_fwd_b (
      .RsE       (hz.Rs2E),
      .RdM       (hz.RdM),
      .RdW       (hz.RdW),
      .RegWriteM (hz.RegWriteM),
      .RegWriteW (hz.RegWriteW),
      .fwd       (fwd_b)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         mem_err  <= mem_err_n;
      end
   end

   // freeze is Mealy: a missed access stalls in the same cycle.
   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      mem_err_n  = mem_err;
      freeze     = 1'b0;
      unique case (state)
         RUN: begin
            if (hz.dmem_req && !hz.dmem_ack) begin
               freeze     = 1'b1;
               state_n    = WAIT;
               wait_cnt_n = WC_W'(1);
            end
         end
         WAIT: begin
            freeze = 1'b1;
            if (hz.dmem_ack)
               state_n = RUN;
            else if (wait_cnt == WC_W'(WAIT_MAX)) begin
               state_n   = ERR;
               mem_err_n = 1'b1;
            end else
               wait_cnt_n = wait_cnt + WC_W'(1);
         end
         ERR: freeze = 1'b1;
         default: begin
            freeze  = 1'b1;
            state_n = RUN;
         end
      endcase
   end

   assign lwstall = hz.LoadE
                  && (hz.RdE != REG_ZERO)
                  && ((hz.RdE == hz.Rs1D)
                   || (hz.RdE == hz.Rs2D));

   assign run  = !reset && !freeze;
   assign en_f = run && !lwstall;

   assign hz.EnF    = en_f;
   assign hz.EnD    = en_f;
   assign hz.EnE    = run;
   assign hz.EnM    = run;
   assign hz.EnW    = run;
   assign hz.FlushD = run && hz.PCSrcE;
   assign hz.FlushE = run && (hz.PCSrcE || lwstall);

   assign hz.ForwardAE = reset ? FWD_NONE : fwd_a;
   assign hz.ForwardBE = reset ? FWD_NONE : fwd_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_q <= '0;
      else if (!en_f && (stall_q != '1))
         stall_q <= stall_q + CNT_W'(1);
   end

   assign hz.mem_err      = mem_err;
   assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl:
// forwarding, load-use, branch flush, dmem wait and timeout.
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] s0;

   pipeline_hazard_ctrl_if #(.CNT_W(32)) hif ();

   pipeline_hazard_ctrl #(
      .WAIT_MAX (16),
      .CNT_W    (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      hif.Rs1D = 0; hif.Rs2D = 0;
      hif.Rs1E = 0; hif.Rs2E = 0;
      hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
      hif.RegWriteM = 0; hif.RegWriteW = 0;
      hif.LoadE = 0; hif.PCSrcE = 0;
      hif.dmem_req = 0; hif.dmem_ack = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      reset = 1'b1;
      hif.RegWriteM = 1; hif.RdM = 5; hif.Rs1E = 5;
      #3;
      chk("rst_enf", 32'(hif.EnF), 0);
      chk("rst_ene", 32'(hif.EnE), 0);
      chk("rst_flush", 32'({hif.FlushD, hif.FlushE}), 0);
      chk("rst_fwda", 32'(hif.ForwardAE), 0);
      chk("rst_err", 32'(hif.mem_err), 0);
      chk("rst_stall", hif.stall_cycles, 0);
      clr();
      #9 reset = 1'b0;
      tick();
      chk("idle_en", 32'({hif.EnF, hif.EnD, hif.EnE,
                          hif.EnM, hif.EnW}), 32'h1f);
      chk("idle_stall", hif.stall_cycles, 0);

      // forwarding
      hif.RdM = 5; hif.RegWriteM = 1; hif.Rs1E = 5;
      hif.RdW = 5; hif.RegWriteW = 1;
      #1;
      chk("fwd_mem_wins", 32'(hif.ForwardAE), 32'h2);
      chk("fwd_b_none", 32'(hif.ForwardBE), 32'h0);
      hif.RdM = 0;
      #1;
      chk("fwd_wb", 32'(hif.ForwardAE), 32'h1);
      hif.Rs2E = 5; hif.RegWriteW = 0;
      #1;
      chk("fwd_no_we", 32'(hif.ForwardBE), 32'h0);
      clr();
      hif.RdM = 0; hif.RegWriteM = 1; hif.Rs2E = 0;
      hif.RdW = 3; hif.RegWriteW = 1; hif.Rs1E = 3;
      #1;
      chk("fwd_x0", 32'(hif.ForwardBE), 32'h0);
      chk("fwd_wb_a", 32'(hif.ForwardAE), 32'h1);
      clr();
      tick();

      // load-use
      s0 = hif.stall_cycles;
      hif.LoadE = 1; hif.RdE = 7; hif.Rs2D = 7;
      #1;
      chk("lu_enfd", 32'({hif.EnF, hif.EnD}), 0);
      chk("lu_flush", 32'({hif.FlushD, hif.FlushE}), 32'h1);
      chk("lu_ene", 32'(hif.EnE), 1);
      tick();
      clr();
      #1;
      chk("lu_stall", hif.stall_cycles, s0 + 1);
      chk("lu_release", 32'(hif.EnF), 1);
      hif.LoadE = 1; hif.RdE = 0;
      #1;
      chk("lu_x0", 32'(hif.EnF), 1);
      clr();
      tick();

      // branch and load-use together
      s0 = hif.stall_cycles;
      hif.PCSrcE = 1; hif.LoadE = 1;
      hif.RdE = 7; hif.Rs1D = 7;
      #1;
      chk("br_lu_flush", 32'({hif.FlushD, hif.FlushE}), 32'h3);
      chk("br_lu_en", 32'({hif.EnF, hif.EnD, hif.EnE}), 32'h1);
      tick();
      clr();
      #1;
      chk("br_lu_stall", hif.stall_cycles, s0 + 1);

      // dmem wait, ack in the fourth frozen cycle
      s0 = hif.stall_cycles;
      hif.dmem_req = 1; hif.PCSrcE = 1;
      for (int i = 0; i < 4; i++) begin
         hif.dmem_ack = (i == 3);
         #1;
         chk("dm_en", 32'({hif.EnF, hif.EnD, hif.EnE,
                           hif.EnM, hif.EnW}), 0);
         chk("dm_flush", 32'({hif.FlushD, hif.FlushE}), 0);
         tick();
      end
      clr();
      #1;
      chk("dm_run", 32'({hif.EnF, hif.EnE}), 32'h3);
      chk("dm_stall", hif.stall_cycles, s0 + 4);
      hif.dmem_req = 1; hif.dmem_ack = 1;
      #1;
      chk("dm_zero_lat", 32'(hif.EnM), 1);
      tick();
      chk("dm_zero_cnt", hif.stall_cycles, s0 + 4);
      clr();

      // timeout
      s0 = hif.stall_cycles;
      hif.dmem_req = 1;
      for (int i = 0; i < 17; i++) begin
         #1;
         chk("to_pre_err", 32'({hif.mem_err, hif.EnF}), 0);
         tick();
      end
      #1;
      chk("to_err", 32'(hif.mem_err), 1);
      chk("to_stall", hif.stall_cycles, s0 + 17);
      clr();
      hif.dmem_ack = 1;
      repeat (3) tick();
      chk("to_frozen", 32'({hif.EnE, hif.EnF}), 0);
      chk("to_sticky", 32'(hif.mem_err), 1);
      #2 reset = 1'b1;
      #1;
      chk("to_rst_err", 32'(hif.mem_err), 0);
      chk("to_rst_stall", hif.stall_cycles, 0);
      chk("to_rst_en", 32'(hif.EnE), 0);
      clr();
      #1 reset = 1'b0;
      #1;
      chk("to_run", 32'({hif.EnF, hif.EnE}), 32'h3);
      tick();
      chk("to_run_stall", hif.stall_cycles, 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
